scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per data channel (1..32).
REQ-002 SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-003 SHALL have derived constant SELW = max(1, ceil(log2(NCH))), channel index width.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IN  input  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port SEL  input  SELW  channel index, used in manual mode.
REQ-008 SHALL have port MODE  input  1  0 = manual select, 1 = round-robin scan.
REQ-009 SHALL have port EN_MASK  input  NCH  per-channel enable; bit k = 1 allows channel k.
REQ-010 SHALL have port OUT_READY  input  1  consumer accepts OUT this cycle.
REQ-011 SHALL have port OUT  output  WIDTH  registered selected data.
REQ-012 SHALL have port OUT_VALID  output  1  OUT holds an unconsumed sample.
REQ-013 SHALL have port OUT_CH  output  SELW  channel index of the sample in OUT.

Function
REQ-014 SHALL define "slot free" = !OUT_VALID || OUT_READY; capture happens only when the slot is free.
REQ-015 SHALL present a capture on OUT/OUT_CH/OUT_VALID at the edge it occurs (1-cycle latency from IN to OUT).
REQ-016 SHALL hold OUT, OUT_CH, OUT_VALID and the scan pointer PTR unchanged while OUT_VALID && !OUT_READY (stall).
REQ-017 SHALL, in manual mode with slot free, capture IN[SEL], set OUT_CH = SEL, set OUT_VALID = 1 if SEL < NCH and EN_MASK[SEL] = 1.
REQ-018 SHALL, in manual mode with slot free and SEL disabled or SEL >= NCH, clear OUT_VALID and leave OUT/OUT_CH unchanged.
REQ-019 SHALL, in scan mode with slot free, capture channel PTR if EN_MASK[PTR] = 1 (as REQ-017), else clear OUT_VALID.
REQ-020 SHALL, in scan mode with slot free, advance PTR by one per cycle, wrapping NCH-1 -> 0; disabled channels consume one cycle each.
REQ-021 SHALL hold PTR in manual mode; a switch into scan mode resumes at the held PTR.
REQ-022 SHALL, with EN_MASK = 0 in scan mode, produce no captures while PTR keeps cycling.
REQ-023 SHALL sample MODE, SEL and EN_MASK every cycle; a change takes effect at the next capture edge without corrupting a held sample.

Reset
REQ-024 SHALL, while RST_N = 0, force OUT = 0, OUT_VALID = 0, OUT_CH = 0, PTR = 0 independent of CLK.
REQ-025 SHALL discard any held sample when reset asserts mid-stall; first capture is possible on the first rising edge after RST_N deasserts.

Configuration
REQ-026 SHALL, with macro SCAN_MUX_PARITY_EN defined, add output port OUT_PAR (1 bit) = even parity (XOR) of OUT, registered with OUT, reset 0, held during stall.
REQ-027 SHALL, without SCAN_MUX_PARITY_EN, have no OUT_PAR port and no parity logic; all other behaviour identical.

Structure
REQ-028 SHALL place the MODE encodings (MODE_MANUAL = 0, MODE_SCAN = 1) and the SELW computation in shared package scan_mux_pkg.
REQ-029 SHALL implement PTR with its wrap and advance logic as sub-module scan_ptr (inputs CLK, RST_N, advance; output PTR).

Verification
REQ-030 SHALL cover manual: WIDTH=8, NCH=4, IN ch2 = 0xA5, SEL=2, EN_MASK=4'b1111, OUT_READY=1 -> next edge OUT=0xA5, OUT_CH=2, OUT_VALID=1.
REQ-031 SHALL cover stall: OUT_VALID=1, OUT_READY=0 for 3 cycles while IN changes -> OUT, OUT_CH, PTR unchanged; ready=1 -> new capture next edge.
REQ-032 SHALL cover scan with mask 4'b1010, OUT_READY=1, from reset -> OUT_CH sequence 1,3,1,3 with OUT_VALID pattern 0,1,0,1,... repeating.
REQ-033 SHALL cover disabled manual channel: SEL=3, EN_MASK[3]=0 -> OUT_VALID=0 after next edge, OUT unchanged.
REQ-034 SHALL cover async reset mid-stall: RST_N low between edges -> OUT=0, OUT_VALID=0, OUT_CH=0 immediately; PTR restarts at 0.
REQ-035 SHALL cover parity build: SCAN_MUX_PARITY_EN defined, captured OUT=0x07 -> OUT_PAR=1; OUT=0x03 -> OUT_PAR=0.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux channel multiplexer: mode encodings
// and the channel-index width helper used by the top and the scan pointer.
package scan_mux_pkg;

  // Operating mode as sampled from the MODE pin.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Supported parameter ranges.
  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned NCH_MIN   = 2;
  localparam int unsigned NCH_MAX   = 16;

  // Channel index width: max(1, ceil(log2(nch))).
  function automatic int unsigned sel_width(input int unsigned nch);
    int unsigned w;
    w = int'($clog2(nch));
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_mux_ptr.sv
// Round-robin scan pointer for scan_mux. Advances by one on each cycle that
// 'advance' is high and wraps from NCH-1 back to 0; otherwise it holds.
module scan_ptr #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            advance,
  output logic [SELW-1:0] PTR
);

  logic [SELW-1:0] ptr_next;

  // Next pointer: increment with wrap at the last channel, else hold.
  always_comb begin
    ptr_next = PTR;
    if (advance) begin
      if (PTR == SELW'(NCH - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = PTR + 1'b1;
      end
    end
  end

  // Pointer register, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PTR <= '0;
    end else begin
      PTR <= ptr_next;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual select and round-robin scan
// modes and a single-entry valid/ready output slot.
// Optional feature: define SCAN_MUX_PARITY_EN to add the OUT_PAR output
// (even parity of OUT, registered alongside it).
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NCH   = 4,
  localparam int unsigned SELW  = sel_width(NCH)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NCH*WIDTH-1:0] IN,
  input  logic [SELW-1:0]      SEL,
  input  logic                 MODE,
  input  logic [NCH-1:0]       EN_MASK,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     OUT,
  output logic                 OUT_VALID,
  output logic [SELW-1:0]      OUT_CH
`ifdef SCAN_MUX_PARITY_EN
  ,
  output logic                 OUT_PAR
`endif
);

  mode_e           mode;
  logic            slot_free;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] cur_ch;
  logic [WIDTH-1:0] sel_data;
  logic            sel_en;
  logic            capture;
  logic            advance;

  logic [WIDTH-1:0] out_next;
  logic [SELW-1:0]  ch_next;
  logic             valid_next;

  assign mode      = mode_e'(MODE);
  assign slot_free = !OUT_VALID || OUT_READY;
  assign cur_ch    = (mode == MODE_SCAN) ? ptr : SEL;

  // The pointer only moves on slot-free cycles in scan mode, so it is frozen
  // during a stall and while in manual mode.
  assign advance = slot_free && (mode == MODE_SCAN);

  scan_ptr #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_ptr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .advance (advance),
    .PTR     (ptr)
  );

  // Channel lookup: indices at or beyond NCH match no channel and read as disabled.
  always_comb begin
    sel_data = '0;
    sel_en   = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cur_ch == SELW'(k)) begin
        sel_data = IN[k*WIDTH +: WIDTH];
        sel_en   = EN_MASK[k];
      end
    end
  end

  assign capture = slot_free && sel_en;

  // Output slot update: capture an enabled channel, drop valid otherwise,
  // and hold everything while the consumer stalls.
  always_comb begin
    out_next   = OUT;
    ch_next    = OUT_CH;
    valid_next = OUT_VALID;
    if (slot_free) begin
      if (sel_en) begin
        out_next   = sel_data;
        ch_next    = cur_ch;
        valid_next = 1'b1;
      end else begin
        valid_next = 1'b0;
      end
    end
  end

  // Output registers, cleared asynchronously so a held sample is discarded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT       <= '0;
      OUT_CH    <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT       <= out_next;
      OUT_CH    <= ch_next;
      OUT_VALID <= valid_next;
    end
  end

`ifdef SCAN_MUX_PARITY_EN
  // Parity register tracks OUT: recomputed only when new data is captured.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_PAR <= 1'b0;
    end else if (capture) begin
      OUT_PAR <= ^sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_scan_mux;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_bus = '0;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0;
  logic [3:0]  en_mask = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
`ifdef SCAN_MUX_PARITY_EN
  logic        out_par;
  logic        out_par5;
`endif

  // Second instance with a non power-of-two channel count.
  logic [19:0] in5 = '0;
  logic [2:0]  sel5 = '0;
  logic        mode5 = 1'b0;
  logic [4:0]  mask5 = '0;
  logic        ready5 = 1'b1;
  logic [3:0]  out5;
  logic        valid5;
  logic [2:0]  ch5;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_out, m_ch, m_valid, m_ptr;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic        ready;
    logic [31:0] in;
    logic [7:0]  exp_out;
    logic [1:0]  exp_ch;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN        (in_bus),
    .SEL       (sel),
    .MODE      (mode),
    .EN_MASK   (en_mask),
    .OUT_READY (out_ready),
    .OUT       (out_data),
    .OUT_VALID (out_valid),
    .OUT_CH    (out_ch)
`ifdef SCAN_MUX_PARITY_EN
    ,
    .OUT_PAR   (out_par)
`endif
  );

  scan_mux #(.WIDTH(4), .NCH(5)) dut5 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN        (in5),
    .SEL       (sel5),
    .MODE      (mode5),
    .EN_MASK   (mask5),
    .OUT_READY (ready5),
    .OUT       (out5),
    .OUT_VALID (valid5),
    .OUT_CH    (ch5)
`ifdef SCAN_MUX_PARITY_EN
    ,
    .OUT_PAR   (out_par5)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_out = 0; m_ch = 0; m_valid = 0; m_ptr = 0;
  endtask

  // One clock of the specification's rules, applied to the current inputs.
  task automatic model_step();
    int ch;
    if (m_valid == 0 || out_ready) begin
      ch = mode ? m_ptr : int'(sel);
      if (ch < NCH && en_mask[ch]) begin
        m_out   = int'((in_bus >> (ch * WIDTH)) & 32'hFF);
        m_ch    = ch;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (mode) m_ptr = (m_ptr + 1) % NCH;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},   32'(out_data),        32'(m_out));
    check({tag, ".ch"},    32'(out_ch),          32'(m_ch));
    check({tag, ".valid"}, 32'(out_valid),       32'(m_valid));
    check({tag, ".ptr"},   32'(dut.u_ptr.PTR),   32'(m_ptr));
`ifdef SCAN_MUX_PARITY_EN
    check({tag, ".par"},   32'(out_par),         32'(^m_out[7:0]));
`endif
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd2, 4'hF,    1'b1, 32'h00A5_0000, 8'hA5, 2'd2, 1'b1};
    vecs[1] = '{1'b0, 2'd3, 4'b0111, 1'b1, 32'hFF00_0000, 8'hA5, 2'd2, 1'b0};
    vecs[2] = '{1'b0, 2'd1, 4'hF,    1'b1, 32'h0000_3C00, 8'h3C, 2'd1, 1'b1};
    vecs[3] = '{1'b0, 2'd0, 4'hF,    1'b0, 32'h0000_0099, 8'h3C, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 4'hF,    1'b1, 32'h0000_0011, 8'h11, 2'd0, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 4'h0,    1'b1, 32'h0000_0022, 8'h11, 2'd0, 1'b0};
    vecs[6] = '{1'b0, 2'd1, 4'hF,    1'b0, 32'h0000_7700, 8'h77, 2'd1, 1'b1};
    vecs[7] = '{1'b0, 2'd2, 4'hF,    1'b0, 32'h0055_0000, 8'h77, 2'd1, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.out",   32'(out_data),      32'h0);
    check("rst.valid", 32'(out_valid),     32'h0);
    check("rst.ch",    32'(out_ch),        32'h0);
    check("rst.ptr",   32'(dut.u_ptr.PTR), 32'h0);
    #3 rst_n = 1'b1;

    // Directed manual-mode vectors.
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; en_mask = vecs[i].mask;
      out_ready = vecs[i].ready; in_bus = vecs[i].in;
      tick();
      check($sformatf("vec%0d.out", i),   32'(out_data),      32'(vecs[i].exp_out));
      check($sformatf("vec%0d.ch", i),    32'(out_ch),        32'(vecs[i].exp_ch));
      check($sformatf("vec%0d.valid", i), 32'(out_valid),     32'(vecs[i].exp_valid));
      check($sformatf("vec%0d.ptr", i),   32'(dut.u_ptr.PTR), 32'h0);
    end

    // Scan with mask 1010 from reset: valid alternates, channels 1,3,1,3.
    do_reset();
    mode = 1'b1; en_mask = 4'b1010; out_ready = 1'b1; in_bus = 32'h4433_2211;
    for (int i = 0; i < 8; i++) begin
      model_step();
      tick();
      check($sformatf("scan%0d.valid", i), 32'(out_valid), 32'(i % 2));
      if (i % 2 == 1) begin
        check($sformatf("scan%0d.ch", i),  32'(out_ch),   (i % 4 == 1) ? 32'd1 : 32'd3);
        check($sformatf("scan%0d.out", i), 32'(out_data), (i % 4 == 1) ? 32'h22 : 32'h44);
      end
      check_model($sformatf("scanm%0d", i));
    end

    // Stall for three cycles while IN changes: sample and pointer held.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_bus = $urandom;
      model_step();
      tick();
      check($sformatf("stall%0d.out", i),   32'(out_data),      32'h44);
      check($sformatf("stall%0d.ch", i),    32'(out_ch),        32'd3);
      check($sformatf("stall%0d.valid", i), 32'(out_valid),     32'd1);
      check($sformatf("stall%0d.ptr", i),   32'(dut.u_ptr.PTR), 32'd0);
    end
    en_mask = 4'hF; out_ready = 1'b1; in_bus = 32'h0102_0304;
    model_step();
    tick();
    check("release.out",   32'(out_data),      32'h04);
    check("release.ch",    32'(out_ch),        32'd0);
    check("release.valid", 32'(out_valid),     32'd1);
    check("release.ptr",   32'(dut.u_ptr.PTR), 32'd1);

    // Asynchronous reset asserted between edges during a stall.
    out_ready = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst.out",   32'(out_data),      32'h0);
    check("arst.valid", 32'(out_valid),     32'h0);
    check("arst.ch",    32'(out_ch),        32'h0);
    check("arst.ptr",   32'(dut.u_ptr.PTR), 32'h0);
    tick();
    #3 rst_n = 1'b1;
    model_reset();
    en_mask = 4'b0001; out_ready = 1'b1;
    model_step();
    tick();
    check("arst_first.out",   32'(out_data),  32'h04);
    check("arst_first.ch",    32'(out_ch),    32'd0);
    check("arst_first.valid", 32'(out_valid), 32'd1);
    check_model("arst_first");

    // Scan with nothing enabled: no captures, pointer keeps cycling.
    en_mask = 4'h0;
    for (int i = 0; i < 6; i++) begin
      model_step();
      tick();
      check_model($sformatf("nomask%0d", i));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      en_mask   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_bus    = $urandom;
      model_step();
      tick();
      check_model($sformatf("rnd%0d", i));
    end

`ifdef SCAN_MUX_PARITY_EN
    mode = 1'b0; sel = 2'd0; en_mask = 4'hF; out_ready = 1'b1;
    in_bus = 32'h0000_0007;
    model_step();
    tick();
    check("par07", 32'(out_par), 32'd1);
    in_bus = 32'h0000_0003;
    model_step();
    tick();
    check("par03", 32'(out_par), 32'd0);
`endif

    // Five-channel instance: out-of-range select and scan wrap at 4 -> 0.
    mode5 = 1'b0; sel5 = 3'd4; mask5 = 5'h1F; ready5 = 1'b1; in5 = 20'hB_0000;
    tick();
    check("n5.out",   32'(out5),   32'hB);
    check("n5.ch",    32'(ch5),    32'd4);
    check("n5.valid", 32'(valid5), 32'd1);
    sel5 = 3'd6;
    tick();
    check("n5_oor6.valid", 32'(valid5), 32'd0);
    check("n5_oor6.out",   32'(out5),   32'hB);
    check("n5_oor6.ch",    32'(ch5),    32'd4);
    sel5 = 3'd7;
    tick();
    check("n5_oor7.valid", 32'(valid5), 32'd0);
    mode5 = 1'b1; in5 = 20'h4_3210;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("n5scan%0d.ch", i),    32'(ch5),    32'(i % 5));
      check($sformatf("n5scan%0d.out", i),   32'(out5),   32'(i % 5));
      check($sformatf("n5scan%0d.valid", i), 32'(valid5), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
